// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operating modes, sequencer
// states and the latched shift direction.
package shift_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  // Direction of an auto sequence; only ever holds SHL or SHR.
  typedef mode_t dir_t;

  function automatic logic is_shift(mode_t m);
    return (m == SHL) || (m == SHR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Command/data bundle of the universal shift register; master drives commands,
// slave (the register) returns contents and sequencer status.
interface univ_shift_reg_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  mode_t              mode;
  logic               sin_l;
  logic               sin_r;
  logic [WIDTH-1:0]   pin;
  logic               start;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   pout;
  logic               sout_l;
  logic               sout_r;
  logic               busy;
  logic               done;

  modport master (
    output mode, sin_l, sin_r, pin, start, count,
    input  pout, sout_l, sout_r, busy, done
  );

  modport slave (
    input  mode, sin_l, sin_r, pin, start, count,
    output pout, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/usr_bit_cell.sv
// One bit slice of the shift register: 4:1 mux over hold, shift-left source,
// shift-right source and parallel input, feeding an async-reset flop.
module usr_bit_cell
  import shift_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  mode_t sel,
  input  logic  shl_in,
  input  logic  shr_in,
  input  logic  pin,
  output logic  q
);
  logic d;

  always_comb begin
    unique case (sel)
      SHL:     d = shl_in;
      SHR:     d = shr_in;
      LOAD:    d = pin;
      default: d = q;
    endcase
  end

  // NOTE: state is updated with <= so every slice samples its neighbour's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end
endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with an auto-shift sequencer that runs a
// programmed number of shifts after a single start pulse.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  univ_shift_reg_if.slave bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;
  mode_t            cell_mode;
  logic [WIDTH-1:0] pout, shl_src, shr_src;

  // NOTE: every variable gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    cell_mode = HOLD;
    unique case (state_q)
      IDLE: begin
        if (bus.start && is_shift(bus.mode)) begin
          // The start edge itself never shifts; it only arms the sequencer.
          if (bus.count != '0) begin
            state_d = RUN;
            cnt_d   = bus.count;
            dir_d   = bus.mode;
          end else begin
            state_d = FIN;
          end
        end else begin
          cell_mode = bus.mode;
        end
      end
      RUN: begin
        cell_mode = dir_q;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= SHL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Serial inputs attach at the ends of the neighbour chain.
  assign shl_src = {pout[WIDTH-2:0], bus.sin_l};
  assign shr_src = {bus.sin_r, pout[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .sel    (cell_mode),
      .shl_in (shl_src[i]),
      .shr_in (shr_src[i]),
      .pin    (bus.pin[i]),
      .q      (pout[i])
    );
  end

  assign bus.pout   = pout;
  assign bus.sout_l = pout[WIDTH-1];
  assign bus.sout_r = pout[0];
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == FIN);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: the driver predicts each edge with a
// behavioural model and queues it; a monitor compares after every edge.
module tb_univ_shift_reg;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    logic [W-1:0] pout;
    logic         busy;
    logic         done;
    bit           gold_en;
    logic [W-1:0] gold;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  // Behavioural model: remaining shifts, pending done flag, direction.
  logic [W-1:0] m_pout;
  int           m_left;
  bit           m_fin;
  mode_t        m_dir;

  univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] shift_val(input mode_t d, input logic [W-1:0] v,
                                             input logic sl, input logic sr);
    if (d == SHL) return (v << 1) | W'(sl);
    return (v >> 1) | (W'(sr) << (W - 1));
  endfunction

  task automatic model_reset();
    m_pout = '0;
    m_left = 0;
    m_fin  = 1'b0;
    m_dir  = SHL;
  endtask

  task automatic step(input mode_t m, input logic sl, input logic sr, input logic [W-1:0] p,
                      input logic st, input logic [CW-1:0] c,
                      input bit gen = 1'b0, input logic [W-1:0] gold = '0);
    exp_t e;
    @(negedge clk);
    bus.mode  = m;
    bus.sin_l = sl;
    bus.sin_r = sr;
    bus.pin   = p;
    bus.start = st;
    bus.count = c;
    if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_left > 0) begin
      m_pout = shift_val(m_dir, m_pout, sl, sr);
      m_left--;
      if (m_left == 0) m_fin = 1'b1;
    end else if (st && (m == SHL || m == SHR)) begin
      if (c > 0) begin
        m_left = int'(c);
        m_dir  = m;
      end else begin
        m_fin = 1'b1;
      end
    end else if (m == LOAD) begin
      m_pout = p;
    end else if (m != HOLD) begin
      m_pout = shift_val(m, m_pout, sl, sr);
    end
    e.pout    = m_pout;
    e.busy    = (m_left > 0);
    e.done    = m_fin;
    e.gold_en = gen;
    e.gold    = gold;
    q.push_back(e);
  endtask

  task automatic idle(input logic [W-1:0] gold);
    step(HOLD, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, gold);
  endtask

  // Assert reset between edges and check the outputs clear without a clock edge.
  task automatic reset_now(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check({tag, "_pout"}, 32'(bus.pout), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("pout",   32'(bus.pout),   32'(e.pout));
      check("busy",   32'(bus.busy),   32'(e.busy));
      check("done",   32'(bus.done),   32'(e.done));
      check("sout_l", 32'(bus.sout_l), 32'(e.pout[W-1]));
      check("sout_r", 32'(bus.sout_r), 32'(e.pout[0]));
      if (e.gold_en) check("gold_pout", 32'(bus.pout), 32'(e.gold));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode  = HOLD;
    bus.sin_l = 1'b0;
    bus.sin_r = 1'b0;
    bus.pin   = '0;
    bus.start = 1'b0;
    bus.count = '0;
    model_reset();
    #12;
    check("por_pout", 32'(bus.pout), 32'h0);
    check("por_busy", 32'(bus.busy), 32'h0);
    check("por_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset from a non-zero value
    step(LOAD, 1'b0, 1'b0, 8'hA5, 1'b0, '0, 1'b1, 8'hA5);
    reset_now("rst_a5");

    // Manual modes
    step(LOAD, 1'b0, 1'b0, 8'hB4, 1'b0, '0, 1'b1, 8'hB4);
    step(SHL,  1'b1, 1'b0, '0,    1'b0, '0, 1'b1, 8'h69);
    step(SHR,  1'b0, 1'b0, '0,    1'b0, '0, 1'b1, 8'h34);
    repeat (3) idle(8'h34);

    // Auto left by 3
    step(LOAD, 1'b0, 1'b0, 8'h81, 1'b0, '0, 1'b1, 8'h81);
    step(SHL,  1'b0, 1'b0, '0, 1'b1, CW'(3), 1'b1, 8'h81);
    idle(8'h02);
    idle(8'h04);
    idle(8'h08);
    idle(8'h08);
    idle(8'h08);

    // Zero count
    step(SHR, 1'b0, 1'b1, '0, 1'b1, '0, 1'b1, 8'h08);
    idle(8'h08);
    idle(8'h08);

    // Inputs ignored while running
    step(LOAD, 1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b1, 8'h00);
    step(SHR,  1'b0, 1'b1, '0,    1'b1, CW'(5), 1'b1, 8'h00);
    step(HOLD, 1'b0, 1'b1, '0,    1'b0, '0,     1'b1, 8'h80);
    step(LOAD, 1'b0, 1'b1, 8'h5A, 1'b1, CW'(2), 1'b1, 8'hC0);
    step(LOAD, 1'b0, 1'b1, 8'h5A, 1'b1, CW'(2), 1'b1, 8'hE0);
    step(HOLD, 1'b0, 1'b1, '0,    1'b0, '0,     1'b1, 8'hF0);
    step(HOLD, 1'b0, 1'b1, '0,    1'b0, '0,     1'b1, 8'hF8);
    step(HOLD, 1'b0, 1'b1, '0,    1'b0, '0,     1'b1, 8'hF8);
    idle(8'hF8);
    idle(8'hF8);

    // Reset mid-run, then normal load
    step(LOAD, 1'b0, 1'b0, 8'h3C, 1'b0, '0, 1'b1, 8'h3C);
    step(SHL,  1'b1, 1'b0, '0, 1'b1, CW'(6), 1'b1, 8'h3C);
    step(HOLD, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 8'h79);
    step(HOLD, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 8'hF3);
    reset_now("rst_run");
    idle(8'h00);
    step(LOAD, 1'b0, 1'b0, 8'h5A, 1'b0, '0, 1'b1, 8'h5A);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(mode_t'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), W'($urandom),
           ($urandom_range(0, 3) == 0), CW'($urandom_range(0, 11)));
    end
    repeat (16) step(HOLD, 1'b0, 1'b0, '0, 1'b0, '0);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with hold, shift-left, shift-right and parallel-load modes, plus an auto-shift sequencer that performs a programmed number of shifts after a single start pulse. It generalises the team's single-bit storage cells into a WIDTH-bit clocked register with asynchronous reset. It sits between parallel producers and serial links, and serves as the storage primitive for serializers and deserializers.

## Interface
- WIDTH, 8: register width in bits (≥2).
- CNT_W, $clog2(WIDTH+1): width of the shift-count input.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  mode_t: 00 HOLD, 01 SHL, 10 SHR, 11 LOAD.
- sin_l  in  1  serial input entering bit 0 on SHL.
- sin_r  in  1  serial input entering bit WIDTH-1 on SHR.
- pin  in  WIDTH  parallel load data.
- start  in  1  request an auto-shift sequence; sampled only in IDLE.
- count  in  CNT_W  number of shifts for the auto sequence.
- pout  out  WIDTH  register contents.
- sout_l  out  1  pout[WIDTH-1], combinational.
- sout_r  out  1  pout[0], combinational.
- busy  out  1  high while the auto sequence runs.
- done  out  1  one-cycle pulse when the auto sequence ends.

## Operation
- Reset (async, immediate): pout=0, busy=0, done=0, state=IDLE, internal counter=0, latched direction=SHL.
- Per-edge update in IDLE when start=0:
  - HOLD: pout unchanged.
  - SHL: pout ← {pout[WIDTH-2:0], sin_l}.
  - SHR: pout ← {sin_r, pout[WIDTH-1:1]}.
  - LOAD: pout ← pin.
- Auto sequence, start=1 in IDLE:
  - mode SHL or SHR with count>0: latch direction and count, go to RUN. This edge does not shift.
  - mode SHL or SHR with count=0: go to FIN. No shift.
  - mode HOLD or LOAD: start is ignored and the mode acts as normal.
- RUN: each edge shifts once in the latched direction, using live sin_l/sin_r, and decrements the counter. When the counter reaches 1 and that shift is taken, go to FIN.
- FIN: done=1 for exactly one cycle, pout holds, then go to IDLE.
- States: IDLE → RUN → FIN → IDLE, or IDLE → FIN for a zero count.
- busy=1 in RUN only.
- While in RUN or FIN, mode, pin, start and count are ignored.
- count > WIDTH is legal. Extra shifts continue filling from the serial input.

## Timing
- Manual modes have 1-cycle latency: pout reflects the operation after the sampling edge.
- Auto sequence with count=N>0:
  - busy rises at the edge that samples start.
  - The N shifts occur on the next N edges.
  - busy falls and done rises on edge N+1 after start.
  - done falls one edge later, and the block is back in IDLE.
  - Total: N+2 cycles from start to accepting new commands.
- Zero count: done is high for the cycle after the start edge. busy stays 0.
- start held high across FIN: re-sampled in IDLE on the edge after done falls, which starts a new sequence.
- Reset asserted mid-RUN: the sequence aborts immediately and all outputs return to reset values. No done pulse.
- sout_l and sout_r have no register stage. They change with pout.

## Structure
- Package shift_pkg holds:
  - mode_t (2-bit enum: HOLD, SHL, SHR, LOAD),
  - state_t (IDLE, RUN, FIN),
  - the dir_t alias (SHL/SHR subset).
- Sub-module usr_bit_cell is one bit slice: a 4:1 mux over hold, left-neighbour, right-neighbour and parallel input, feeding a flop with async reset. It is instantiated WIDTH times by generate.
- The top level holds the FSM, the counter and the neighbour wiring. Serial inputs attach at the ends.

## Test plan
- Reset: assert rst mid-cycle with pout=8'hA5 → pout=8'h00, busy=0, done=0 immediately, without waiting for an edge.
- Manual modes: LOAD pin=8'hB4 → pout=8'hB4. Then SHL with sin_l=1 → 8'h69. Then SHR with sin_r=0 → 8'h34. Then HOLD for 3 cycles → 8'h34 stable.
- Auto left: pout=8'h81, mode=SHL, count=3, sin_l=0, start pulse:
  - busy is high for 3 cycles,
  - pout passes 8'h02, 8'h04, 8'h08,
  - done is high for 1 cycle after the third shift, with pout=8'h08.
- Zero count: count=0, mode=SHR, start → done pulse one cycle later, busy never high, pout unchanged.
- Ignored inputs during RUN: count=5 SHR with sin_r=1 from 8'h00. Toggle mode to LOAD and pulse start mid-run → pout=8'hF8 at done, and no second sequence starts.
- Reset mid-RUN: count=6, assert rst after 2 shifts → immediate return to reset values, no done. After release, the block accepts LOAD normally.
